imu_spi_arbiter: RTL



---
 rtl/imu_spi_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/imu_spi_arbiter.sv
`timescale 1ns/1ps
// imu_spi_arbiter: round-robin sharing of one single-byte SPI engine among N_REQ requesters,
// with an engine timeout and an enforced idle gap after every transaction.
module imu_spi_arbiter #(
   parameter int N_REQ          = 4,
   parameter int GAP_CYCLES     = 1000,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_addr,
   input  logic [8*N_REQ-1:0] req_wdata,
   input  logic [N_REQ-1:0]   req_read,
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   ack,
   output logic               err,
   output logic [7:0]         rdata,
   output logic [7:0]         spi_addr,
   output logic [7:0]         spi_wdata,
   output logic               spi_read,
   output logic               spi_enable,
   input  logic               spi_done,
   input  logic [7:0]         spi_rdata
);
   localparam int LW = $clog2(N_REQ);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, ISSUE, BUSY, ACK, GAP} state_t;

   state_t        state, state_nx;
   logic [LW-1:0] last, owner, pick;
   logic [GW-1:0] gap_cnt;
   logic [TW-1:0] tmo_cnt;
   logic          any_req, done_q, done_rise, timed_out, err_q;
   int            best;

   // winner is the requester at the smallest rotational distance past last
   always_comb begin
      pick = '0;
      best = N_REQ;
      for (int i = 0; i < N_REQ; i++)
         if (req[i] && (i + N_REQ - 1 - int'(last)) % N_REQ < best) begin
            best = (i + N_REQ - 1 - int'(last)) % N_REQ;
            pick = LW'(i);
         end
   end

   assign any_req   = |req;
   assign done_rise = spi_done & ~done_q;
   assign timed_out = tmo_cnt >= TW'(TIMEOUT_CYCLES);

   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else        state <= state_nx;

   always_comb begin
      state_nx   = state;
      spi_enable = 1'b0;
      ack        = '0;
      err        = 1'b0;
      case (state)
         IDLE:    state_nx = any_req ? ISSUE : IDLE;
         ISSUE: begin
            spi_enable = 1'b1;
            state_nx   = BUSY;
         end
         BUSY:    state_nx = (done_rise || timed_out) ? ACK : BUSY;
         ACK: begin
            ack      = gnt;
            err      = err_q;
            state_nx = GAP;
         end
         GAP:     state_nx = (gap_cnt == GW'(GAP_CYCLES - 1)) ? IDLE : GAP;
         default: state_nx = IDLE;
      endcase
   end

   // done_q tracks the engine every cycle, so a level still high from the
   // previous transaction never looks like a fresh edge in BUSY
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         gnt       <= '0;
         owner     <= '0;
         last      <= LW'(N_REQ - 1);
         rdata     <= '0;
         spi_addr  <= '0;
         spi_wdata <= '0;
         spi_read  <= 1'b0;
         gap_cnt   <= '0;
         tmo_cnt   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q <= spi_done;
         case (state)
            IDLE: if (any_req) begin
               gnt       <= N_REQ'(1) << pick;
               owner     <= pick;
               spi_addr  <= req_addr[{pick, 3'b000} +: 8];
               spi_wdata <= req_wdata[{pick, 3'b000} +: 8];
               spi_read  <= req_read[pick];
               tmo_cnt   <= '0;
               err_q     <= 1'b0;
            end
            ISSUE: tmo_cnt <= tmo_cnt + 1'b1;
            BUSY: begin
               if (!timed_out) tmo_cnt <= tmo_cnt + 1'b1;
               if (done_rise) rdata <= spi_rdata;
               else if (timed_out) err_q <= 1'b1;
            end
            ACK: begin
               gnt     <= '0;
               last    <= owner;
               gap_cnt <= '0;
            end
            GAP: gap_cnt <= gap_cnt + 1'b1;
            default: ;
         endcase
      end
endmodule
